// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: packs decoded RISC-V fields into 32-bit words
// and writes them to instruction memory at sequential word addresses.
module instr_stream_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          DEPTH     = 64,
  localparam int unsigned         CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        kind,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [20:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_I   = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_SW  = 3'd3;
  localparam logic [2:0] K_BR  = 3'd4;
  localparam logic [2:0] K_JAL = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  logic [31:0]         enc_c;
  logic                bad_c;
  logic                xfer_c;
  logic [CNT_W-1:0]    count_inc_c;
  logic [ADDR_W-1:0]   word_addr_c;

  // Field packing per opcode class; bad_c flags bundles that must not be written
  always_comb begin
    enc_c = '0;
    bad_c = 1'b0;
    case (kind)
      K_R: begin
        enc_c = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      end
      K_I: begin
        enc_c = {imm[11:0], rs1, funct3, rd, OP_I};
        // Shifts reuse the upper immediate bits as the funct7 field
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc_c[31:25] = {1'b0, funct7b5, 5'b00000};
        end
      end
      K_LW: begin
        enc_c = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
      end
      K_SW: begin
        enc_c = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
      end
      K_BR: begin
        enc_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
        bad_c = imm[0];
      end
      K_JAL: begin
        enc_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad_c = imm[0];
      end
      default: begin
        bad_c = 1'b1;
      end
    endcase
  end

  // Handshake and address generation
  assign in_ready    = (state_q == S_LOAD) & ~start;
  assign xfer_c      = in_valid & in_ready;
  assign count_inc_c = count_q + CNT_W'(1);
  assign word_addr_c = BASE_ADDR + (ADDR_W'(count_q) << 2);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;

    if (start) begin
      state_d = S_LOAD;
      count_d = '0;
      err_d   = 1'b0;
    end else if (xfer_c) begin
      if (bad_c) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        we_d    = 1'b1;
        addr_d  = word_addr_c;
        wdata_d = enc_c;
        count_d = count_inc_c;
        if (in_last || count_inc_c == CNT_W'(DEPTH)) begin
          state_d = S_DONE;
        end
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: two instances share stimulus,
// one with DEPTH=64 and one with DEPTH=4 for the capacity limit.
module tb_instr_stream_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  kind;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [20:0] imm;

  logic        rdy_a, we_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic [6:0]  count_a;

  logic        rdy_b, we_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b;
  logic [2:0]  count_b;

  int checks = 0;
  int errors = 0;

  instr_stream_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
    .in_last(in_last), .kind(kind), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
  );

  instr_stream_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
    .in_last(in_last), .kind(kind), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [20:0] im, input logic last);
    in_valid = 1'b1;
    kind     = k;
    funct3   = f3;
    funct7b5 = f7;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
    in_last  = last;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    kind = '0; funct3 = '0; funct7b5 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick();
    tick();

    // Reset state
    chk("rst_we",    32'(we_a),    32'd0);
    chk("rst_addr",  addr_a,       32'd0);
    chk("rst_wdata", wdata_a,      32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    chk("rst_ready", 32'(rdy_a),   32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);

    // Start a program, stream five instructions back-to-back
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    bundle(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    #1;
    chk("load_busy",  32'(busy_a), 32'd1);
    chk("load_ready", 32'(rdy_a),  32'd1);
    tick();
    chk("add_we",    32'(we_a),    32'd1);
    chk("add_addr",  addr_a,       32'h0);
    chk("add_wdata", wdata_a,      32'h002081B3);
    chk("add_count", 32'(count_a), 32'd1);

    bundle(3'd2, 3'b000, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8, 1'b0);
    tick();
    chk("lw_we",    32'(we_a),    32'd1);
    chk("lw_addr",  addr_a,       32'h4);
    chk("lw_wdata", wdata_a,      32'h00812283);

    bundle(3'd3, 3'b000, 1'b0, 5'd0, 5'd2, 5'd5, 21'd12, 1'b0);
    tick();
    chk("sw_we",    32'(we_a),    32'd1);
    chk("sw_addr",  addr_a,       32'h8);
    chk("sw_wdata", wdata_a,      32'h00512623);
    chk("sw_count", 32'(count_a), 32'd3);

    bundle(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFF8, 1'b0);
    tick();
    chk("br_we",    32'(we_a), 32'd1);
    chk("br_addr",  addr_a,    32'hC);
    chk("br_wdata", wdata_a,   32'hFE208CE3);

    bundle(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd16, 1'b1);
    tick();
    chk("jal_we",    32'(we_a),    32'd1);
    chk("jal_addr",  addr_a,       32'h10);
    chk("jal_wdata", wdata_a,      32'h010000EF);
    chk("jal_count", 32'(count_a), 32'd5);
    chk("jal_done",  32'(done_a),  32'd1);
    chk("jal_ready", 32'(rdy_a),   32'd0);
    chk("jal_busy",  32'(busy_a),  32'd0);
    tick();
    chk("done_no_we",  32'(we_a),    32'd0);
    chk("done_count",  32'(count_a), 32'd5);
    in_valid = 1'b0;

    // I-ALU: plain immediate and arithmetic shift
    start = 1'b1;
    tick();
    start = 1'b0;
    bundle(3'd1, 3'b000, 1'b0, 5'd5, 5'd6, 5'd0, 21'h000FFF, 1'b0);
    tick();
    chk("addi_wdata", wdata_a, 32'hFFF30293);
    chk("addi_addr",  addr_a,  32'h0);
    bundle(3'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 21'd3, 1'b1);
    tick();
    chk("srai_wdata", wdata_a,    32'h40315093);
    chk("srai_addr",  addr_a,     32'h4);
    chk("srai_done",  32'(done_a), 32'd1);
    in_valid = 1'b0;

    // Invalid kind: consumed, no write, error, DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    bundle(3'd6, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("k6_we",    32'(we_a),    32'd0);
    chk("k6_err",   32'(err_a),   32'd1);
    chk("k6_done",  32'(done_a),  32'd1);
    chk("k6_count", 32'(count_a), 32'd0);

    // Fresh start clears err; misaligned branch after one good write
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_err",   32'(err_a),   32'd0);
    chk("restart_count", 32'(count_a), 32'd0);
    bundle(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    tick();
    chk("pre_br_we", 32'(we_a), 32'd1);
    bundle(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("brodd_we",    32'(we_a),    32'd0);
    chk("brodd_err",   32'(err_a),   32'd1);
    chk("brodd_done",  32'(done_a),  32'd1);
    chk("brodd_count", 32'(count_a), 32'd1);

    // Capacity limit on the DEPTH=4 instance: six bundles offered
    start = 1'b1;
    tick();
    start = 1'b0;
    bundle(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int n;
      n = (i < 4) ? i : 3;
      tick();
      chk($sformatf("cap_we_%0d", i),    32'(we_b),    (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("cap_addr_%0d", i),  addr_b,       32'(4 * n));
      chk($sformatf("cap_count_%0d", i), 32'(count_b), 32'(n + 1));
      chk($sformatf("cap_done_%0d", i),  32'(done_b),  (i >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("cap_ready_%0d", i), 32'(rdy_b),   (i >= 3) ? 32'd0 : 32'd1);
    end
    in_valid = 1'b0;

    // start together with in_valid: bundle refused
    start = 1'b1;
    tick();
    bundle(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    #1;
    chk("startv_ready", 32'(rdy_a), 32'd0);
    tick();
    chk("startv_we",    32'(we_a),    32'd0);
    chk("startv_count", 32'(count_a), 32'd0);
    start = 1'b0;
    tick();
    chk("post_start_we",    32'(we_a),    32'd1);
    chk("post_start_count", 32'(count_a), 32'd1);

    // Reset with a transfer pending: write dropped, all outputs cleared
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_we",    32'(we_a),    32'd0);
    chk("mrst_addr",  addr_a,       32'd0);
    chk("mrst_wdata", wdata_a,      32'd0);
    chk("mrst_count", 32'(count_a), 32'd0);
    chk("mrst_busy",  32'(busy_a),  32'd0);
    chk("mrst_done",  32'(done_a),  32'd0);
    chk("mrst_ready", 32'(rdy_a),   32'd0);
    tick();
    chk("idle_no_we", 32'(we_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
